mem_wb_stage: RTL and testbench

//  MEM stage of the 5-stage MIPS pipeline. Consumes the EX/MEM register outputs
//  (WB controls, MemRead/MemWrite, ALU result, store data, destination reg).

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/mem_wb_reg.sv | 39 +++
 rtl/mem_wb_stage.sv | 175 +++++++++++++++++
 tb/tb_mem_wb_stage.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline back end: MEM-stage FSM states and the MEM/WB bundle.
package pipe_pkg;

    localparam int unsigned PIPE_DATA_W  = 32;
    localparam int unsigned PIPE_RADDR_W = 5;

    typedef enum logic {
        StIdle = 1'b0,
        StWait = 1'b1
    } mem_state_e;

    // Fields of the MEM/WB register feeding the write-back mux.
    typedef struct packed {
        logic                    reg_write;
        logic                    mem_to_reg;
        logic [PIPE_DATA_W-1:0]  alu_result;
        logic [PIPE_DATA_W-1:0]  read_data;
        logic [PIPE_RADDR_W-1:0] rd_addr;
    } mem_wb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A bubble clears only the write-back controls so the
// datapath fields keep their last values; read_data has its own load enable.
module mem_wb_reg
    import pipe_pkg::*;
(
    input  logic    i_clk,
    input  logic    i_rst_n,
    input  logic    i_load,
    input  logic    i_bubble,
    input  logic    i_rdata_load,
    input  mem_wb_t i_next,
    output mem_wb_t o_q
);

    mem_wb_t r_q;

    // Load / bubble / hold, with read_data updated only on load completion.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else begin
            if (i_bubble) begin
                r_q.reg_write  <= 1'b0;
                r_q.mem_to_reg <= 1'b0;
            end else if (i_load) begin
                r_q.reg_write  <= i_next.reg_write;
                r_q.mem_to_reg <= i_next.mem_to_reg;
                r_q.alu_result <= i_next.alu_result;
                r_q.rd_addr    <= i_next.rd_addr;
            end
            if (i_rdata_load) begin
                r_q.read_data <= i_next.read_data;
            end
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage: data-memory access over req/ack, upstream stall, timeout watchdog,
// and the MEM/WB register. DATA_W/RADDR_W must match the pipe_pkg bundle widths.
module mem_wb_stage
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W  = PIPE_DATA_W,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned RADDR_W = PIPE_RADDR_W,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               valid_i,
    input  logic               reg_write_i,
    input  logic               mem_to_reg_i,
    input  logic               mem_read_i,
    input  logic               mem_write_i,
    input  logic [DATA_W-1:0]  alu_result_i,
    input  logic [DATA_W-1:0]  write_data_i,
    input  logic [RADDR_W-1:0] rd_addr_i,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic [DATA_W-1:0]  mem_wdata_o,
    input  logic               mem_ack_i,
    input  logic [DATA_W-1:0]  mem_rdata_i,
    output logic               stall_o,
    output logic               reg_write_o,
    output logic               mem_to_reg_o,
    output logic [DATA_W-1:0]  alu_result_o,
    output logic [DATA_W-1:0]  read_data_o,
    output logic [RADDR_W-1:0] rd_addr_o,
    output logic               misalign_o,
    output logic               timeout_o
);

    localparam int unsigned     CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic            TO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_e         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_timeout;
    logic               r_misalign;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_reg_write;
    logic               r_mem_to_reg;
    logic [DATA_W-1:0]  r_alu;
    logic [RADDR_W-1:0] r_rd;
    logic               r_is_load;

    logic    w_mem_op;
    logic    w_misalign;
    logic    w_access;
    logic    w_to_hit;
    logic    w_load;
    logic    w_bubble;
    logic    w_rdata_load;
    mem_wb_t w_next;
    mem_wb_t w_q;

    assign w_mem_op   = valid_i & (mem_read_i | mem_write_i);
    assign w_misalign = w_mem_op & (alu_result_i[1:0] != 2'b00);
    assign w_access   = w_mem_op & (alu_result_i[1:0] == 2'b00);
    // Last WAIT cycle before giving up; stall drops here so EX/MEM moves past the access.
    assign w_to_hit   = TO_EN & (r_state == StWait) & ~mem_ack_i & (r_cnt == TO_LAST);

    // FSM, request latch, timeout counter and registered status flags.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_timeout    <= 1'b0;
            r_misalign   <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_alu        <= '0;
            r_rd         <= '0;
            r_is_load    <= 1'b0;
        end else begin
            r_misalign <= (r_state == StIdle) & w_misalign;
            unique case (r_state)
                StIdle: begin
                    if (w_access) begin
                        r_state      <= StWait;
                        r_cnt        <= '0;
                        r_we         <= mem_write_i;
                        r_addr       <= ADDR_W'(alu_result_i);
                        r_wdata      <= write_data_i;
                        r_reg_write  <= reg_write_i;
                        r_mem_to_reg <= mem_to_reg_i;
                        r_alu        <= alu_result_i;
                        r_rd         <= rd_addr_i;
                        // Read+write together is a store.
                        r_is_load    <= mem_read_i & ~mem_write_i;
                    end
                end
                StWait: begin
                    if (mem_ack_i) begin
                        r_state <= StIdle;
                    end else if (w_to_hit) begin
                        r_state   <= StIdle;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // MEM/WB load selection: direct from inputs in IDLE, from the latch on ack.
    always_comb begin
        w_load       = 1'b0;
        w_bubble     = 1'b0;
        w_rdata_load = 1'b0;
        w_next       = '0;
        if (r_state == StIdle) begin
            w_next.reg_write  = reg_write_i;
            w_next.mem_to_reg = mem_to_reg_i;
            w_next.alu_result = alu_result_i;
            w_next.rd_addr    = rd_addr_i;
            if (valid_i & ~w_mem_op) begin
                w_load = 1'b1;
            end else begin
                w_bubble = 1'b1;
            end
        end else begin
            w_next.reg_write  = r_reg_write;
            w_next.mem_to_reg = r_mem_to_reg;
            w_next.alu_result = r_alu;
            w_next.rd_addr    = r_rd;
            w_next.read_data  = mem_rdata_i;
            if (mem_ack_i) begin
                w_load       = 1'b1;
                w_rdata_load = r_is_load;
            end else if (w_to_hit) begin
                w_bubble = 1'b1;
            end
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .i_clk        (clk_i),
        .i_rst_n      (rst_n_i),
        .i_load       (w_load),
        .i_bubble     (w_bubble),
        .i_rdata_load (w_rdata_load),
        .i_next       (w_next),
        .o_q          (w_q)
    );

    // Stall is gated by reset so it drops immediately with the rest of the outputs.
    assign stall_o = rst_n_i & (((r_state == StIdle) & w_access) |
                                ((r_state == StWait) & ~mem_ack_i & ~w_to_hit));

    assign mem_req_o    = (r_state == StWait);
    assign mem_we_o     = r_we;
    assign mem_addr_o   = r_addr;
    assign mem_wdata_o  = r_wdata;
    assign misalign_o   = r_misalign;
    assign timeout_o    = r_timeout;
    assign reg_write_o  = w_q.reg_write;
    assign mem_to_reg_o = w_q.mem_to_reg;
    assign alu_result_o = w_q.alu_result;
    assign read_data_o  = w_q.read_data;
    assign rd_addr_o    = w_q.rd_addr;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with TIMEOUT=8.
module tb_mem_wb_stage;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        valid_i, reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i;
    logic [31:0] alu_result_i, write_data_i;
    logic [4:0]  rd_addr_i;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        stall_o, reg_write_o, mem_to_reg_o;
    logic [31:0] alu_result_o, read_data_o;
    logic [4:0]  rd_addr_o;
    logic        misalign_o, timeout_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    mem_wb_stage #(.TIMEOUT(8)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .valid_i      (valid_i),
        .reg_write_i  (reg_write_i),
        .mem_to_reg_i (mem_to_reg_i),
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .alu_result_i (alu_result_i),
        .write_data_i (write_data_i),
        .rd_addr_i    (rd_addr_i),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i),
        .stall_o      (stall_o),
        .reg_write_o  (reg_write_o),
        .mem_to_reg_o (mem_to_reg_o),
        .alu_result_o (alu_result_o),
        .read_data_o  (read_data_o),
        .rd_addr_o    (rd_addr_o),
        .misalign_o   (misalign_o),
        .timeout_o    (timeout_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        valid_i = 0; reg_write_i = 0; mem_to_reg_i = 0; mem_read_i = 0; mem_write_i = 0;
        alu_result_i = 0; write_data_i = 0; rd_addr_i = 0;
    endtask

    initial begin
        rst_n_i = 0; mem_ack_i = 0; mem_rdata_i = 0;
        idle_inputs();
        #12;
        check("rst_reg_write", reg_write_o, 0);
        check("rst_mem_req", mem_req_o, 0);
        check("rst_stall", stall_o, 0);
        check("rst_timeout", timeout_o, 0);
        check("rst_alu", alu_result_o, 0);
        step();
        rst_n_i = 1;

        // ALU op, no memory access
        valid_i = 1; reg_write_i = 1; alu_result_i = 32'h10; rd_addr_i = 5'd3;
        #1 check("alu_stall_pre", stall_o, 0);
        step();
        check("alu_result", alu_result_o, 32'h10);
        check("alu_rd", rd_addr_o, 3);
        check("alu_reg_write", reg_write_o, 1);
        check("alu_stall", stall_o, 0);
        idle_inputs();
        step();
        check("bubble_reg_write", reg_write_o, 0);

        // Load 0x40, ack in the third WAIT cycle
        valid_i = 1; reg_write_i = 1; mem_to_reg_i = 1; mem_read_i = 1;
        alu_result_i = 32'h40; rd_addr_i = 5'd5;
        #1 check("ld_stall_c0", stall_o, 1);
        check("ld_req_c0", mem_req_o, 0);
        step();
        check("ld_req", mem_req_o, 1);
        check("ld_we", mem_we_o, 0);
        check("ld_addr", mem_addr_o, 32'h40);
        check("ld_stall_c1", stall_o, 1);
        check("ld_wait_bubble", reg_write_o, 0);
        step();
        check("ld_stall_c2", stall_o, 1);
        step();
        mem_ack_i = 1; mem_rdata_i = 32'hDEADBEEF;
        #1 check("ld_stall_ack", stall_o, 0);
        check("ld_req_ack", mem_req_o, 1);
        step();
        mem_ack_i = 0; mem_rdata_i = 0;
        idle_inputs();
        check("ld_rdata", read_data_o, 32'hDEADBEEF);
        check("ld_mem_to_reg", mem_to_reg_o, 1);
        check("ld_reg_write", reg_write_o, 1);
        check("ld_rd", rd_addr_o, 5);
        check("ld_alu", alu_result_o, 32'h40);
        check("ld_req_done", mem_req_o, 0);

        // Stray ack while idle must not touch read_data
        mem_ack_i = 1; mem_rdata_i = 32'h11111111;
        step();
        mem_ack_i = 0; mem_rdata_i = 0;
        check("idle_ack_rdata", read_data_o, 32'hDEADBEEF);
        check("idle_ack_req", mem_req_o, 0);

        // Store 0x44 <- 0x1234, inputs disturbed during WAIT
        valid_i = 1; mem_write_i = 1; alu_result_i = 32'h44; write_data_i = 32'h1234;
        rd_addr_i = 5'd7;
        step();
        alu_result_i = 32'h80; write_data_i = 32'hFFFF; mem_write_i = 0; mem_read_i = 1;
        #1 check("st_wdata", mem_wdata_o, 32'h1234);
        check("st_we", mem_we_o, 1);
        check("st_addr", mem_addr_o, 32'h44);
        step();
        mem_ack_i = 1;
        #1 check("st_wdata_ack", mem_wdata_o, 32'h1234);
        step();
        mem_ack_i = 0;
        idle_inputs();
        check("st_reg_write", reg_write_o, 0);
        check("st_rdata_hold", read_data_o, 32'hDEADBEEF);
        check("st_alu", alu_result_o, 32'h44);

        // Misaligned load 0x42
        valid_i = 1; reg_write_i = 1; mem_to_reg_i = 1; mem_read_i = 1;
        alu_result_i = 32'h42; rd_addr_i = 5'd9;
        #1 check("mis_stall", stall_o, 0);
        step();
        idle_inputs();
        check("mis_pulse", misalign_o, 1);
        check("mis_req", mem_req_o, 0);
        check("mis_bubble", reg_write_o, 0);
        step();
        check("mis_pulse_end", misalign_o, 0);

        // Timeout: load 0x48, never acked
        valid_i = 1; reg_write_i = 1; mem_to_reg_i = 1; mem_read_i = 1;
        alu_result_i = 32'h48; rd_addr_i = 5'd4;
        step();
        idle_inputs();
        for (int i = 0; i < 7; i++) step();
        check("to_not_yet", timeout_o, 0);
        check("to_req_last", mem_req_o, 1);
        step();
        check("to_flag", timeout_o, 1);
        check("to_stall", stall_o, 0);
        check("to_req", mem_req_o, 0);
        check("to_bubble", reg_write_o, 0);
        mem_ack_i = 1; mem_rdata_i = 32'h5555;
        step();
        mem_ack_i = 0; mem_rdata_i = 0;
        check("to_late_ack", read_data_o, 32'hDEADBEEF);
        check("to_sticky", timeout_o, 1);

        // Reset during WAIT
        valid_i = 1; reg_write_i = 1; mem_read_i = 1; alu_result_i = 32'h4C;
        step();
        check("rw_req", mem_req_o, 1);
        rst_n_i = 0;
        #1 check("rw_req_rst", mem_req_o, 0);
        check("rw_stall_rst", stall_o, 0);
        check("rw_rdata_rst", read_data_o, 0);
        check("rw_alu_rst", alu_result_o, 0);
        check("rw_timeout_rst", timeout_o, 0);
        idle_inputs();
        step();
        rst_n_i = 1;
        step();
        check("rw_req_after", mem_req_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
